// File: rtl/freq_gate_ctrl_if.sv
// Bus bundle between the measurement sequencer and the counter/display side.
// With FGC_ACK_EN defined, the bundle also carries the display acknowledge.
interface freq_gate_ctrl_if;
    logic       RUN;
    logic [1:0] RANGE;
    logic       CNT_OVF;
`ifdef FGC_ACK_EN
    logic       ACK;
`endif
    logic       RST_CNT;
    logic       CNT_EN;
    logic       LOAD;
    logic       VALID;
    logic       OVF;
    logic [1:0] RANGE_Q;
    logic       BUSY;

`ifdef FGC_ACK_EN
    modport master (
        input  RUN, RANGE, CNT_OVF, ACK,
        output RST_CNT, CNT_EN, LOAD, VALID, OVF, RANGE_Q, BUSY
    );
    modport slave (
        output RUN, RANGE, CNT_OVF, ACK,
        input  RST_CNT, CNT_EN, LOAD, VALID, OVF, RANGE_Q, BUSY
    );
`else
    modport master (
        input  RUN, RANGE, CNT_OVF,
        output RST_CNT, CNT_EN, LOAD, VALID, OVF, RANGE_Q, BUSY
    );
    modport slave (
        output RUN, RANGE, CNT_OVF,
        input  RST_CNT, CNT_EN, LOAD, VALID, OVF, RANGE_Q, BUSY
    );
`endif
endinterface

// File: rtl/freq_gate_ctrl.sv
// Frequency-meter measurement sequencer: clear, gate, settle, load, wait.
// Optional macro FGC_ACK_EN: WAIT holds until the display acknowledges.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no measurement, strobes low, waits for RUN
// S_CLEAR  | one-cycle counter clear, range latched, sticky ovf cleared
// S_GATE   | CNT_EN high for GATE_BASE * 10^range cycles
// S_SETTLE | gate closed, SETTLE cycles for the ripple counter
// S_LOAD   | one-cycle result latch, VALID/OVF/RANGE_Q updated
// S_WAIT   | result presented (HOLD cycles, or until ACK)
module freq_gate_ctrl #(
    parameter int GATE_BASE = 5000000,
    parameter int SETTLE    = 4,
    parameter int HOLD      = 16
) (
    input logic              CLK,
    input logic              RST,
    freq_gate_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_LOAD, S_WAIT
    } state_t;

    // The base counter doubles as the SETTLE/HOLD timer, so it must hold all three loads.
    localparam int TMR_MAX = (GATE_BASE > SETTLE) ?
                             ((GATE_BASE > HOLD) ? GATE_BASE : HOLD) :
                             ((SETTLE > HOLD) ? SETTLE : HOLD);
    localparam int TMR_W = $clog2(TMR_MAX);

    localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_BASE - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] base_q, base_d;
    logic [9:0]       dec_q, dec_d;
    logic [1:0]       range_q, range_d;
    logic             sticky_q, sticky_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       range_out_q, range_out_d;

    function automatic logic [9:0] dec_load(input logic [1:0] r);
        logic [9:0] v;
        case (r)
            2'd0: v = 10'd0;
            2'd1: v = 10'd9;
            2'd2: v = 10'd99;
            2'd3: v = 10'd999;
        endcase
        return v;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            dec_q       <= '0;
            range_q     <= '0;
            sticky_q    <= 1'b0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            range_out_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            dec_q       <= dec_d;
            range_q     <= range_d;
            sticky_q    <= sticky_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            range_out_q <= range_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        dec_d       = dec_q;
        range_d     = range_q;
        sticky_d    = sticky_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        range_out_d = range_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.RUN) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d  = S_GATE;
                range_d  = bus.RANGE;
                sticky_d = 1'b0;
                base_d   = GATE_LD;
                dec_d    = dec_load(bus.RANGE);
            end
            S_GATE: begin
                sticky_d = sticky_q | bus.CNT_OVF;
                if (base_q == '0) begin
                    if (dec_q == '0) begin
                        state_d = S_SETTLE;
                        base_d  = SETTLE_LD;
                    end else begin
                        dec_d  = dec_q - 10'd1;
                        base_d = GATE_LD;
                    end
                end else begin
                    base_d = base_q - TMR_W'(1);
                end
            end
            S_SETTLE: begin
                sticky_d = sticky_q | bus.CNT_OVF;
                if (base_q == '0) state_d = S_LOAD;
                else              base_d  = base_q - TMR_W'(1);
            end
            S_LOAD: begin
                state_d = S_WAIT;
                base_d  = HOLD_LD;
            end
            S_WAIT: begin
`ifdef FGC_ACK_EN
                if (bus.ACK) begin
                    valid_d = 1'b0;
                    state_d = bus.RUN ? S_CLEAR : S_IDLE;
                end
`else
                if (base_q == '0) state_d = bus.RUN ? S_CLEAR : S_IDLE;
                else              base_d  = base_q - TMR_W'(1);
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Result flags are registered on the edge entering CLEAR/LOAD so they are visible in that cycle.
        if (state_d == S_CLEAR) valid_d = 1'b0;
        if (state_q == S_SETTLE && state_d == S_LOAD) begin
            valid_d     = 1'b1;
            ovf_d       = sticky_d;
            range_out_d = range_q;
        end
    end

    always_comb begin
        bus.RST_CNT = (state_q == S_CLEAR);
        bus.CNT_EN  = (state_q == S_GATE);
        bus.LOAD    = (state_q == S_LOAD);
        bus.BUSY    = (state_q != S_IDLE);
        bus.VALID   = valid_q;
        bus.OVF     = ovf_q;
        bus.RANGE_Q = range_out_q;
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: offset-based reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_freq_gate_ctrl;
    localparam int GB = 10;
    localparam int ST = 2;
    localparam int HD = 3;

    logic clk = 1'b0;
    logic rst;
    freq_gate_ctrl_if bif();

    freq_gate_ctrl #(.GATE_BASE(GB), .SETTLE(ST), .HOLD(HD)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pow10(input int r);
        int v = 1;
        for (int i = 0; i < r; i++) v = v * 10;
        return v;
    endfunction

    // Reference model: a measurement is a timeline of offsets from its CLEAR cycle.
    bit m_active = 0;
    int m_off = 0;
    int m_n = GB;
    int m_range = 0;
    bit m_sticky = 0;
    bit e_valid = 0;
    bit e_ovf = 0;
    int e_rq = 0;
    bit chk_en = 0;
    int load_off;
    bit done;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            chk_en   = 1;
            m_active = 0;
            e_valid  = 0;
            e_ovf    = 0;
            e_rq     = 0;
            m_sticky = 0;
        end else if (m_active) begin
            if (m_off == 0) begin
                m_range  = int'(bif.RANGE);
                m_n      = GB * pow10(m_range);
                m_sticky = 0;
            end else if (m_off <= m_n + ST && bif.CNT_OVF) begin
                m_sticky = 1;
            end
            load_off = m_n + 1 + ST;
`ifdef FGC_ACK_EN
            done = (m_off > load_off) && bif.ACK;
            if (done) e_valid = 0;
`else
            done = (m_off == load_off + HD);
`endif
            if (done) begin
                if (bif.RUN) m_off = 0;
                else         m_active = 0;
            end else begin
                m_off++;
            end
            if (m_active && m_off == load_off) begin
                e_valid = 1;
                e_ovf   = m_sticky;
                e_rq    = m_range;
            end
        end else if (bif.RUN) begin
            m_active = 1;
            m_off    = 0;
        end
        if (!rst && m_active && m_off == 0) e_valid = 0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rst_cnt", bif.RST_CNT, m_active && m_off == 0);
            chk("cnt_en",  bif.CNT_EN,  m_active && m_off >= 1 && m_off <= m_n);
            chk("load",    bif.LOAD,    m_active && m_off == m_n + 1 + ST);
            chk("busy",    bif.BUSY,    m_active);
            chk("valid",   bif.VALID,   e_valid);
            chk("ovf",     bif.OVF,     e_ovf);
            chk("range_q", bif.RANGE_Q, e_rq);
        end
    end

    // Event monitor feeding the literal checks.
    int clr_cyc = 0, load_cyc = 0, load_gap = 0, en_len = 0, load_cnt = 0;
    always @(negedge clk) begin
        if (bif.RST_CNT) begin
            en_len  = 0;
            clr_cyc = cyc;
        end
        if (bif.CNT_EN) en_len++;
        if (bif.LOAD) begin
            load_gap = cyc - load_cyc;
            load_cyc = cyc;
            load_cnt++;
        end
    end

    logic       v_after, o_after;
    logic [1:0] rq_after;
    int c, n0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_load(input int bound);
        for (int i = 0; i < bound && !bif.LOAD; i++) tick(1);
        chk("load_seen", bif.LOAD, 1);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && bif.BUSY; i++) tick(1);
        chk("idle_reached", bif.BUSY, 0);
    endtask

    task automatic finish_meas(input int bound);
        wait_load(bound);
        tick(1);
        v_after  = bif.VALID;
        o_after  = bif.OVF;
        rq_after = bif.RANGE_Q;
`ifdef FGC_ACK_EN
        tick(2);
        bif.ACK = 1;
        tick(1);
        bif.ACK = 0;
`endif
        wait_idle(20);
    endtask

    initial begin
        rst = 1;
        bif.RUN = 0;
        bif.RANGE = 0;
        bif.CNT_OVF = 0;
`ifdef FGC_ACK_EN
        bif.ACK = 0;
`endif
        tick(3);
        rst = 0;
        tick(1);
        chk("reset_busy", bif.BUSY, 0);
        chk("reset_valid", bif.VALID, 0);

        // Range 0 single shot
        bif.RANGE = 0;
        bif.RUN = 1;
        c = cyc;
        tick(1);
        bif.RUN = 0;
        chk("r0_clear_now", bif.RST_CNT, 1);
        finish_meas(100);
        chk("r0_clear_cycle", clr_cyc - c, 1);
        chk("r0_load_cycle", load_cyc - c, 14);
        chk("r0_gate_len", en_len, 10);
        chk("r0_valid", v_after, 1);
        chk("r0_range_q", rq_after, 0);

        // Range 2 with RANGE changed during the gate
        bif.RANGE = 2;
        bif.RUN = 1;
        tick(1);
        bif.RUN = 0;
        tick(1);
        bif.RANGE = 0;
        finish_meas(1200);
        chk("r2_gate_len", en_len, 1000);
        chk("r2_range_q", rq_after, 2);

        // Overflow pulse in the first SETTLE cycle, then a clean measurement
        bif.RUN = 1;
        tick(1);
        bif.RUN = 0;
        tick(11);
        bif.CNT_OVF = 1;
        tick(1);
        bif.CNT_OVF = 0;
        finish_meas(100);
        chk("ovf_set", o_after, 1);
        bif.RUN = 1;
        tick(1);
        bif.RUN = 0;
        finish_meas(100);
        chk("ovf_clean", o_after, 0);

`ifdef FGC_ACK_EN
        bif.RUN = 1;
        tick(1);
        bif.RUN = 0;
        tick(3);
        bif.ACK = 1;
        tick(3);
        bif.ACK = 0;
        wait_load(100);
        tick(50);
        chk("ack_hold_valid", bif.VALID, 1);
        chk("ack_hold_busy", bif.BUSY, 1);
        chk("ack_hold_no_clear", bif.RST_CNT, 0);
        bif.RUN = 1;
        bif.ACK = 1;
        tick(1);
        bif.ACK = 0;
        bif.RUN = 0;
        chk("ack_valid_clr", bif.VALID, 0);
        chk("ack_clear_follows", bif.RST_CNT, 1);
        finish_meas(100);
`else
        bif.RUN = 1;
        tick(60);
        chk("cont_load_gap", load_gap, 17);
        for (int i = 0; i < 40 && !bif.CNT_EN; i++) tick(1);
        chk("cont_in_gate", bif.CNT_EN, 1);
        n0 = load_cnt;
        bif.RUN = 0;
        wait_idle(100);
        chk("cont_one_more_load", load_cnt, n0 + 1);
`endif

        // Reset in the middle of the gate
        bif.RUN = 1;
        tick(1);
        bif.RUN = 0;
        tick(5);
        rst = 1;
        tick(1);
        chk("rst_rst_cnt", bif.RST_CNT, 0);
        chk("rst_cnt_en", bif.CNT_EN, 0);
        chk("rst_load", bif.LOAD, 0);
        chk("rst_valid", bif.VALID, 0);
        chk("rst_ovf", bif.OVF, 0);
        chk("rst_range_q", bif.RANGE_Q, 0);
        chk("rst_busy", bif.BUSY, 0);
        tick(2);
        rst = 0;
        bif.RUN = 1;
        tick(1);
        bif.RUN = 0;
        chk("rst_restart_clear", bif.RST_CNT, 1);
        finish_meas(100);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) bif.RUN = ~bif.RUN;
            bif.RANGE = ($urandom_range(0, 99) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
            bif.CNT_OVF = ($urandom_range(0, 7) == 0);
`ifdef FGC_ACK_EN
            bif.ACK = ($urandom_range(0, 5) == 0);
`endif
            rst = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 0;
        bif.RUN = 0;
        bif.CNT_OVF = 0;
`ifdef FGC_ACK_EN
        bif.ACK = 1;
`endif
        wait_idle(3000);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Measurement sequencer for the frequency-meter counter datapath, running on the system clock. Generates counter clear, gate (count-enable) and result-latch pulses in a fixed, repeatable order. Gate length is selectable by decade range. Reports completion and overflow to the display side.

## Interface
Parameters:
- GATE_BASE, 5000000: CLK cycles in a range-0 gate (0.1 s at 50 MHz); must be ≥2.
- SETTLE, 4: idle cycles between gate close and LOAD, letting the ripple counter settle; must be ≥1.
- HOLD, 16: cycles VALID is held before restarting, used only when the ACK feature is compiled out; must be ≥1.

Ports:
- CLK  in  1  system clock, all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- RUN  in  1  high: perform measurements back-to-back.
- RANGE  in  2  gate length = GATE_BASE × 10^RANGE; sampled only in CLEAR.
- CNT_OVF  in  1  overflow flag from the counter datapath.
- ACK  in  1  display consumed result; present only with FGC_ACK_EN.
- RST_CNT  out  1  counter clear, one-cycle pulse.
- CNT_EN  out  1  gate; counter counts while high.
- LOAD  out  1  latch counter into result register, one-cycle pulse.
- VALID  out  1  result register holds a fresh measurement.
- OVF  out  1  overflow status of the last loaded measurement.
- RANGE_Q  out  2  range of the last loaded measurement.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, GATE, SETTLE, LOAD, WAIT.
- IDLE: all strobes low. RUN=1 → CLEAR.
- CLEAR: lasts 1 cycle.
  - RST_CNT=1.
  - RANGE is latched into an internal range register.
  - Sticky overflow is cleared.
  - VALID is cleared.
  - Next state: GATE.
- GATE: CNT_EN=1 for exactly GATE_BASE × 10^range cycles, then → SETTLE.
  - Timing uses a base counter (0..GATE_BASE-1) and a decade counter (0..10^range-1).
  - The decade counter advances on base-counter wrap.
- SETTLE: CNT_EN=0 for SETTLE cycles, then → LOAD.
- LOAD: lasts 1 cycle.
  - LOAD=1.
  - VALID is set in this same cycle.
  - OVF ← sticky overflow; RANGE_Q ← range register.
  - Next state: WAIT.
- WAIT: see Configuration. On exit: → CLEAR if RUN=1, else → IDLE. VALID stays high into IDLE.
- Sticky overflow: set by CNT_OVF=1 sampled in GATE or SETTLE; ignored in all other states.
- RUN deasserted during CLEAR, GATE, SETTLE or LOAD: the current measurement completes fully, and the FSM then returns to IDLE. It never aborts.
- RANGE changes outside CLEAR have no effect on the measurement in progress.
- RST at any cycle, including mid-gate:
  - Next state is IDLE.
  - All outputs 0: RST_CNT, CNT_EN, LOAD, VALID, OVF, BUSY = 0, RANGE_Q = 0.
  - All counters and sticky overflow are cleared.
- Strobes are mutually exclusive: RST_CNT, CNT_EN and LOAD are never high together.
- All outputs are registered (state-decoded from registered state, no input-to-output combinational path).

## Timing
- Let N = GATE_BASE × 10^range. If RUN is sampled high in IDLE at edge 0:
  - CLEAR occupies cycle 1.
  - GATE occupies cycles 2..N+1.
  - SETTLE occupies N+2..N+1+SETTLE.
  - LOAD is at N+2+SETTLE.
- Exit from WAIT to CLEAR: the cycle after the exit condition.
- Back-to-back period without ACK: 1 + N + SETTLE + 1 + HOLD cycles.
- Counter widths:
  - Base counter: clog2(GATE_BASE) bits.
  - Decade counter: 10 bits (max 999).
  - No other arithmetic.

## Configuration
- Macro FGC_ACK_EN.
- Defined:
  - ACK port exists.
  - WAIT holds until ACK=1 is sampled.
  - VALID clears on the edge where ACK is sampled high.
  - The FSM exits WAIT on that same edge.
  - ACK outside WAIT is ignored.
  - WAIT has no timeout.
- Undefined:
  - No ACK port.
  - WAIT lasts exactly HOLD cycles, then exits.
  - VALID remains high until the next CLEAR.

## Test plan
Bench parameters: GATE_BASE=10, SETTLE=2, HOLD=3.
- Reset: RST high 3 cycles mid-GATE → next cycle all outputs 0 and BUSY=0. After release, RUN=1 restarts from CLEAR.
- Range 0 single shot: RUN pulsed 1 cycle, RANGE=0 → RST_CNT at cycle 1, CNT_EN high exactly 10 cycles, LOAD at cycle 14, VALID=1, RANGE_Q=0, then IDLE.
- Range 2: RANGE=2 at CLEAR, changed to 0 during GATE → CNT_EN high exactly 1000 cycles, RANGE_Q=2.
- Overflow: CNT_OVF pulsed 1 cycle during SETTLE → OVF=1 at LOAD. The next measurement without CNT_OVF → OVF=0.
- Continuous, ACK compiled out: RUN held high → LOAD pulses exactly 17 cycles apart. Dropping RUN mid-GATE finishes that measurement, then IDLE.
- With FGC_ACK_EN: ACK withheld 50 cycles → FSM stays in WAIT with VALID=1. ACK=1 → VALID=0 next cycle and CLEAR follows. ACK in GATE has no effect.
